// File: rtl/countdown6.sv
// ---------------------------------------------------------------------------
// countdown6 : loadable 6-bit down counter with start/busy/done handshake.
//
// The counter is loaded with a required number of enabled cycles. It
// decrements while busy and en are high. When the count reaches zero it
// raises a single-cycle done pulse. A load while busy aborts the current run
// without producing done. A load of zero completes at once with a done pulse.
//
// Ports
//   clk       in   1  rising-edge clock
//   clr       in   1  asynchronous reset, active-low
//   load      in   1  synchronous start, captures load_val (highest priority)
//   load_val  in   6  cycles to run, 0..63
//   en        in   1  count enable, only effective while busy
//   out       out  6  remaining count, registered
//   busy      out  1  count in progress, registered
//   done      out  1  one-cycle terminal pulse, registered
//   zero      out  1  combinational (out == 0)
// ---------------------------------------------------------------------------
module countdown6 (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       en,
  output logic [5:0] out,
  output logic       busy,
  output logic       done,
  output logic       zero
);

  // The state encoding is {busy, done}. Both outputs are therefore plain
  // register bits, and the two flags cannot be high together in any legal state.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DONE = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       dec_en_s;
  logic       last_s;
  logic [5:0] cnt_dec_s;

  // Borrow-chain decrement. Bit i toggles when every lower bit is 0 and
  // the chain is enabled. This is the up-counter's carry chain with the
  // inverted bit sense.
  function automatic logic [5:0] borrow_dec(input logic [5:0] v, input logic g);
    logic [5:0] r;
    logic       borrow;
    borrow = g;
    for (int i = 0; i < 6; i++) begin
      r[i]   = v[i] ^ borrow;
      borrow = borrow & ~v[i];
    end
    return r;
  endfunction

  // Decrement qualification and terminal-count detection
  always_comb begin
    dec_en_s  = (state_q == ST_RUN) & en;
    last_s    = (cnt_q == 6'd1);
    cnt_dec_s = borrow_dec(cnt_q, dec_en_s);
  end

  // State and count registers, asynchronously cleared by clr
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load first, then decrement, then hold
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    if (load) begin
      cnt_d = load_val;
      if (load_val != 6'd0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en) begin
            cnt_d   = cnt_dec_s;
            state_d = last_s ? ST_DONE : ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        // done lasts exactly one cycle
        ST_DONE: state_d = ST_IDLE;
        ST_IDLE: state_d = ST_IDLE;
        default: begin
          // Unreachable encoding {1,1}: recover to idle and keep the count.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: each output is a register bit, except zero
  always_comb begin
    out  = cnt_q;
    busy = state_q[1];
    done = state_q[0];
    zero = (cnt_q == 6'd0);
  end

endmodule

// File: tb/tb_countdown6.sv
module tb_countdown6;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_val = 6'd0;
  logic       en = 1'b0;
  logic [5:0] out;
  logic       busy;
  logic       done;
  logic       zero;

  int tests = 0;
  int fails = 0;

  // Reference model: remaining count plus the two status flags
  int m_out  = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  countdown6 dut (
    .clk(clk), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .out(out), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " out"},  {26'd0, out}, m_out);
    check({tag, " busy"}, {31'd0, busy}, {31'd0, m_busy});
    check({tag, " done"}, {31'd0, done}, {31'd0, m_done});
    check({tag, " zero"}, {31'd0, zero}, (m_out == 0) ? 32'd1 : 32'd0);
    check({tag, " excl"}, {31'd0, busy & done}, 32'd0);
  endtask

  task automatic model_reset();
    m_out  = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock edge: apply inputs, advance the model, compare after the edge
  task automatic step(input string tag, input bit ld, input int val, input bit e);
    load     = ld;
    load_val = val[5:0];
    en       = e;
    @(posedge clk);
    if (!clr) begin
      model_reset();
    end else if (ld) begin
      m_out  = val;
      m_busy = (val != 0);
      m_done = (val == 0);
    end else if (m_busy && e) begin
      m_out  = m_out - 1;
      m_busy = (m_out != 0);
      m_done = (m_out == 0);
    end else begin
      m_done = 1'b0;
    end
    #1;
    check_all(tag);
    load = 1'b0;
    en   = 1'b0;
  endtask

  int exp_out[6];
  int done_cnt;
  int n;

  initial begin
    // Reset state
    #1;
    check_all("rst_init");
    step("rst_hold0", 1'b1, 7, 1'b1);
    #2 clr = 1'b1;

    // Async clear mid-run with out=5, busy=1
    step("pre_rst", 1'b1, 5, 1'b0);
    check("pre_rst out5", {26'd0, out}, 32'd5);
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst zero", {31'd0, zero}, 32'd1);
    step("rst_hold1", 1'b0, 0, 1'b1);
    step("rst_hold2", 1'b1, 9, 1'b1);
    #2 clr = 1'b1;

    // Basic count of 3
    step("basic_ld", 1'b1, 3, 1'b1);
    check("basic_ld out", {26'd0, out}, 32'd3);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step("basic", 1'b0, 0, 1'b1);
      check("basic out", {26'd0, out}, (i < 3) ? 2 - i : 0);
      check("basic done", {31'd0, done}, (i == 2) ? 32'd1 : 32'd0);
    end

    // Stall: en pattern 1,0,0,1,1,1
    step("stall_ld", 1'b1, 4, 1'b0);
    exp_out = '{3, 3, 3, 2, 1, 0};
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step("stall", 1'b0, 0, (i == 1 || i == 2) ? 1'b0 : 1'b1);
      check("stall out", {26'd0, out}, exp_out[i]);
      if (done) done_cnt++;
    end
    check("stall done_last", {31'd0, done}, 32'd1);
    step("stall_after", 1'b0, 0, 1'b0);
    check("stall done_cnt", done_cnt, 32'd1);

    // Zero load
    step("zero_ld", 1'b1, 0, 1'b1);
    check("zero_ld done", {31'd0, done}, 32'd1);
    check("zero_ld busy", {31'd0, busy}, 32'd0);
    step("zero_after", 1'b0, 0, 1'b1);

    // Max load: done after exactly 63 decrements, no wrap afterwards
    step("max_ld", 1'b1, 63, 1'b1);
    n = 0;
    while (!done && n < 70) begin
      step("max", 1'b0, 0, 1'b1);
      n++;
    end
    check("max decrements", n, 32'd63);
    for (int i = 0; i < 3; i++) begin
      step("max_nowrap", 1'b0, 0, 1'b1);
      check("max nowrap out", {26'd0, out}, 32'd0);
    end

    // Reload while busy
    step("reld_ld", 1'b1, 10, 1'b1);
    for (int i = 0; i < 4; i++) step("reld_run", 1'b0, 0, 1'b1);
    check("reld out6", {26'd0, out}, 32'd6);
    step("reld_ld2", 1'b1, 2, 1'b1);
    check("reld out2", {26'd0, out}, 32'd2);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step("reld", 1'b0, 0, 1'b1);
      if (done) done_cnt++;
      check("reld done timing", {31'd0, done}, (i == 1) ? 32'd1 : 32'd0);
    end
    check("reld done_cnt", done_cnt, 32'd1);

    // Load coincident with done
    step("coin_ld", 1'b1, 1, 1'b1);
    step("coin_done", 1'b0, 0, 1'b1);
    check("coin done", {31'd0, done}, 32'd1);
    step("coin_reld", 1'b1, 5, 1'b1);
    check("coin out", {26'd0, out}, 32'd5);
    check("coin busy", {31'd0, busy}, 32'd1);
    check("coin done0", {31'd0, done}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int  v;
      bit  ld;
      bit  e;
      ld = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0:       v = 0;
        1:       v = 63;
        2:       v = 1;
        default: v = $urandom_range(0, 63);
      endcase
      e = ($urandom_range(0, 3) != 0);
      step("rand", ld, v, e);
      if ($urandom_range(0, 199) == 0) begin
        #2 clr = 1'b0;
        #1;
        model_reset();
        check_all("rand_async");
        step("rand_rsthold", 1'b1, $urandom_range(0, 63), 1'b1);
        #2 clr = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
